alu_issue_sequencer: RTL and testbench
======================================

ALU_ISSUE_SEQUENCER -- requirements
Module: alu_issue_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: instruction buffer entries, power of two.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-005 SHALL have port in_inst  input  16  instruction: opcode[2:0], func[6:3], reg2[9:7], reg1[12:10], regw[15:13].
REQ-006 SHALL have port in_ready  output  1  buffer can accept; equals not-full.
REQ-007 SHALL have port rf_raddr1  output  3  register file read address 1 (reg1).
REQ-008 SHALL have port rf_raddr2  output  3  register file read address 2 (reg2).
REQ-009 SHALL have port alu_func  output  4  ALU control (func).
REQ-010 SHALL have port alu_result  input  8  combinational ALU result.
REQ-011 SHALL have port alu_zero  input  1  ALU zero flag.
REQ-012 SHALL have port rf_we  output  1  register file write strobe.
REQ-013 SHALL have port rf_waddr  output  3  register file write address (regw).
REQ-014 SHALL have port rf_wdata  output  8  register file write data.
REQ-015 SHALL have port res_valid  output  1  result available.
REQ-016 SHALL have port res_ready  input  1  downstream accepts result.
REQ-017 SHALL have port res_data  output  8  captured ALU result.
REQ-018 SHALL have port res_zero  output  1  captured zero flag.
REQ-019 SHALL have port busy  output  1  high when state is not IDLE or buffer non-empty.
REQ-020 SHALL have port op_count  output  8  count of completed (result-accepted) operations.

Function
REQ-021 SHALL push in_inst into the FIFO on every edge where in_valid and in_ready are both high; no bypass (entry visible at head on the following cycle).
REQ-022 SHALL deassert in_ready when FIFO holds FIFO_DEPTH entries; in_valid while full is ignored, FIFO contents unchanged.
REQ-023 SHALL implement states IDLE, READ, EXEC, WRITE, RESP.
REQ-024 IDLE with FIFO non-empty: pop head into instruction latch; opcode 011 or 010 -> READ; any other opcode -> discarded, remain IDLE, no result, op_count unchanged.
REQ-025 READ: one cycle for registered register-file read -> EXEC.
REQ-026 EXEC: capture alu_result into res_data and alu_zero into res_zero; opcode 011 -> WRITE; opcode 010 -> RESP.
REQ-027 WRITE: rf_we high for exactly this one cycle, rf_waddr = latched regw, rf_wdata = res_data -> RESP.
REQ-028 RESP: res_valid high and res_data/res_zero stable until an edge with res_ready high; on that edge -> IDLE and op_count increments.
REQ-029 op_count SHALL wrap 255 -> 0.
REQ-030 rf_raddr1, rf_raddr2, alu_func, rf_waddr SHALL always reflect the instruction latch (held between instructions).
REQ-031 rf_we SHALL be low in every state other than WRITE.
REQ-032 Pushes SHALL continue during READ/EXEC/WRITE/RESP; pop only occurs in IDLE; simultaneous push and pop in the same cycle keeps occupancy unchanged.
REQ-033 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH without losing order.
REQ-034 Latency: accept edge E0 -> pop E1 -> res_valid high from E4 (opcode 011, rf_we high E3..E4) or from E3 (opcode 010).

Reset
REQ-035 rst_n low SHALL immediately force: state IDLE, FIFO empty, in_ready 1, rf_we 0, res_valid 0, res_data 0, res_zero 0, instruction latch 0 (so raddr/waddr/func 0), op_count 0, busy 0.
REQ-036 Reset mid-operation SHALL abandon the in-flight instruction with no write strobe and flush all buffered instructions.

Verification
REQ-037 Push 0x6533 (ADD r3=r1+r2), model returns alu_result 0x03 in EXEC, res_ready=1 -> rf_we one cycle with waddr 3, wdata 0x03; res_valid at E4, res_data 0x03, res_zero 0, op_count 1.
REQ-038 Push compare (opcode 010, func 1101, reg1=reg2=5), alu_result 0x01 -> no rf_we, res_valid at E3, res_data 0x01.
REQ-039 Hold res_ready=0, push 6 instructions -> in_ready low after 4 buffered plus 1 in flight as applicable; no push lost or duplicated; results emerge in order after res_ready=1.
REQ-040 Push opcode 000 between two 011 instructions -> only two results, op_count 2, no extra rf_we.
REQ-041 Assert rst_n=0 during WRITE -> rf_we drops immediately, FIFO empty, res_valid 0, op_count 0.
REQ-042 Complete 256 operations -> op_count reads 0.

Source files
------------

// File: rtl/alu_issue_sequencer.sv
// ALU issue sequencer: buffers 16-bit instructions in a small FIFO and walks
// each executable one through register read, ALU execute, optional register
// write-back, and a handshaked result response.
module alu_issue_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] in_inst,
    output logic        in_ready,
    output logic [2:0]  rf_raddr1,
    output logic [2:0]  rf_raddr2,
    output logic [3:0]  alu_func,
    input  logic [7:0]  alu_result,
    input  logic        alu_zero,
    output logic        rf_we,
    output logic [2:0]  rf_waddr,
    output logic [7:0]  rf_wdata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_data,
    output logic        res_zero,
    output logic        busy,
    output logic [7:0]  op_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    // Opcodes that actually execute; everything else is dropped at issue.
    localparam logic [2:0] OP_ALU_WB   = 3'b011;  // execute and write back
    localparam logic [2:0] OP_ALU_RESP = 3'b010;  // execute, respond only

    typedef enum logic [2:0] {
        IDLE,
        READ,
        EXEC,
        WRITE,
        RESP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] inst_q, inst_d;
    logic [7:0]  res_data_q, res_data_d;
    logic        res_zero_q, res_zero_d;
    logic [7:0]  op_count_q, op_count_d;

    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [15:0] fifo_head;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = in_valid && !fifo_full;
    assign fifo_head  = fifo_mem[rd_ptr_q[AW-1:0]];

    assign in_ready  = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign rf_raddr1 = inst_q[12:10];
    assign rf_raddr2 = inst_q[9:7];
    assign alu_func  = inst_q[6:3];
    assign rf_waddr  = inst_q[15:13];
    assign rf_wdata  = res_data_q;
    assign res_data  = res_data_q;
    assign res_zero  = res_zero_q;
    assign op_count  = op_count_q;

    // Instruction storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[AW-1:0]] <= in_inst;
        end
    end

    // Pointer advance: push from upstream, pop only when the sequencer is idle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    // Sequencer next-state and per-state outputs.
    always_comb begin
        state_d    = state_q;
        inst_d     = inst_q;
        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        op_count_d = op_count_q;
        pop        = 1'b0;
        rf_we      = 1'b0;
        res_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    inst_d = fifo_head;
                    if ((fifo_head[2:0] == OP_ALU_WB) || (fifo_head[2:0] == OP_ALU_RESP)) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // Register file read is registered; give it one cycle.
                state_d = EXEC;
            end
            EXEC: begin
                res_data_d = alu_result;
                res_zero_d = alu_zero;
                state_d    = (inst_q[2:0] == OP_ALU_WB) ? WRITE : RESP;
            end
            WRITE: begin
                rf_we   = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d    = IDLE;
                    op_count_d = op_count_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset flushes the buffer and abandons any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inst_q     <= '0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inst_q     <= inst_d;
            res_data_q <= res_data_d;
            res_zero_q <= res_zero_d;
            op_count_q <= op_count_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer: a register file and ALU live in the bench,
// a reference model replays accepted instructions in order and predicts
// results, write-backs and the operation count.
module tb_alu_issue_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_inst;
    logic        in_ready;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [3:0]  alu_func;
    logic [7:0]  alu_result;
    logic        alu_zero;
    logic        rf_we;
    logic [7:0]  rf_wdata;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic        res_zero;
    logic        busy;
    logic [7:0]  op_count;

    int total = 0;
    int bad   = 0;

    logic [7:0]  rf_mem [8];
    logic [7:0]  m_rf [8];
    int          m_cnt;
    logic [15:0] acc_q [$];
    logic [8:0]  got_res [$];
    logic [10:0] got_wr [$];
    logic [8:0]  exp_res [$];
    logic [10:0] exp_wr [$];
    logic        rr_rand = 1'b0;
    logic        hold_prev = 1'b0;
    logic [8:0]  hold_val;

    alu_issue_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst),
        .in_ready(in_ready), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .alu_func(alu_func), .alu_result(alu_result), .alu_zero(alu_zero),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_zero(res_zero), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // ALU behaviour shared by the environment and the reference model.
    function automatic logic [7:0] alu_fn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'b0110: return a + b;
            4'b1101: return (a == b) ? 8'd1 : 8'd0;
            4'b0000: return a & b;
            default: return a ^ b ^ {f, f};
        endcase
    endfunction

    assign alu_result = alu_fn(alu_func, rf_mem[rf_raddr1], rf_mem[rf_raddr2]);
    assign alu_zero   = (alu_result == 8'd0);

    // Register file in the environment; reset restores r[i] = i.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'(i);
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    // Random downstream backpressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rr_rand) res_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Observe accepted results and write strobes mid-cycle; check response stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("resp_hold_valid", 32'(res_valid), 32'd1);
                check("resp_hold_data", 32'({res_zero, res_data}), 32'(hold_val));
            end
            hold_prev = res_valid && !res_ready;
            hold_val  = {res_zero, res_data};
            if (res_valid && res_ready) got_res.push_back({res_zero, res_data});
            if (rf_we) got_wr.push_back({rf_waddr, rf_wdata});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called with in_valid/in_inst already driven; returns 1ns after the accept edge.
    task automatic wait_accept();
        bit ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("push_accept", 32'(ok), 32'd1);
        @(posedge clk);
        if (ok) acc_q.push_back(in_inst);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [15:0] inst);
        in_inst  = inst;
        in_valid = 1'b1;
        wait_accept();
    endtask

    function automatic logic [15:0] rand_inst(input logic [2:0] op);
        logic [15:0] v;
        v      = 16'($urandom);
        v[2:0] = op;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 8'(i);
        m_cnt = 0;
        acc_q.delete();
        got_res.delete();
        got_wr.delete();
    endtask

    // Let the DUT go idle, then replay accepted instructions through the model and compare.
    task automatic drain_and_compare(input string tag);
        bit idle = 1'b0;
        logic [15:0] inst;
        logic [7:0]  r;
        res_ready = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (!busy && !in_valid) begin
                idle = 1'b1;
                break;
            end
            step(1);
        end
        check({tag, "_drain"}, 32'(idle), 32'd1);
        exp_res.delete();
        exp_wr.delete();
        foreach (acc_q[i]) begin
            inst = acc_q[i];
            if (inst[2:0] == 3'b011 || inst[2:0] == 3'b010) begin
                r = alu_fn(inst[6:3], m_rf[inst[12:10]], m_rf[inst[9:7]]);
                exp_res.push_back({(r == 8'd0), r});
                if (inst[2:0] == 3'b011) begin
                    exp_wr.push_back({inst[15:13], r});
                    m_rf[inst[15:13]] = r;
                end
                m_cnt++;
            end
        end
        check({tag, "_res_count"}, 32'(got_res.size()), 32'(exp_res.size()));
        check({tag, "_wr_count"}, 32'(got_wr.size()), 32'(exp_wr.size()));
        for (int i = 0; i < got_res.size() && i < exp_res.size(); i++)
            check({tag, "_res"}, 32'(got_res[i]), 32'(exp_res[i]));
        for (int i = 0; i < got_wr.size() && i < exp_wr.size(); i++)
            check({tag, "_wr"}, 32'(got_wr[i]), 32'(exp_wr[i]));
        check({tag, "_op_count"}, 32'(op_count), 32'(m_cnt % 256));
        acc_q.delete();
        got_res.delete();
        got_wr.delete();
    endtask

    initial begin
        bit saw_we;
        logic [2:0] op;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_inst = 16'h0;
        res_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_latch", 32'({rf_raddr1, rf_raddr2, alu_func, rf_waddr, res_data, res_zero}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // ADD r3 = r1 + r2 with exact cycle placement.
        res_ready = 1'b1;
        push(16'h6533);                     // now at E0+1
        step(1);                            // E1+1: popped into latch
        check("add_latch", 32'({rf_raddr1, rf_raddr2, alu_func}), 32'({3'd1, 3'd2, 4'd6}));
        step(2);                            // E3+1
        check("add_we_e3", 32'(rf_we), 32'd1);
        check("add_waddr", 32'(rf_waddr), 32'd3);
        check("add_wdata", 32'(rf_wdata), 32'h03);
        check("add_valid_e3", 32'(res_valid), 32'd0);
        step(1);                            // E4+1
        check("add_we_e4", 32'(rf_we), 32'd0);
        check("add_valid_e4", 32'(res_valid), 32'd1);
        check("add_res", 32'({res_zero, res_data}), 32'h003);
        step(1);
        check("add_op_count", 32'(op_count), 32'd1);
        drain_and_compare("add");

        // Compare r5 == r5: response only, earlier by one cycle.
        push(16'h16EA);
        step(2);                            // E2+1
        check("cmp_valid_e2", 32'(res_valid), 32'd0);
        step(1);                            // E3+1
        check("cmp_valid_e3", 32'(res_valid), 32'd1);
        check("cmp_res", 32'(res_data), 32'h01);
        check("cmp_we", 32'(rf_we), 32'd0);
        drain_and_compare("cmp");

        // Backpressure: one in flight plus four buffered fills the FIFO.
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(rand_inst(3'b011));
        check("full_in_ready", 32'(in_ready), 32'd0);
        in_inst  = rand_inst(3'b011);
        in_valid = 1'b1;
        step(3);
        check("full_blocked", 32'(in_ready), 32'd0);
        check("full_busy", 32'(busy), 32'd1);
        res_ready = 1'b1;
        wait_accept();
        drain_and_compare("bp");

        // Non-executable opcode sandwiched between two write-backs.
        push(rand_inst(3'b011));
        push(rand_inst(3'b000));
        push(rand_inst(3'b011));
        drain_and_compare("skip");

        // Random traffic with random backpressure and gaps.
        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1:    op = 3'b011;
                2:       op = 3'b010;
                default: op = 3'($urandom);
            endcase
            push(rand_inst(op));
            step($urandom_range(0, 2));
        end
        rr_rand = 1'b0;
        step(1);
        drain_and_compare("rand");

        // Reset during WRITE abandons work and flushes the buffer.
        res_ready = 1'b1;
        push(rand_inst(3'b011));
        push(rand_inst(3'b011));
        saw_we = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (rf_we) begin
                saw_we = 1'b1;
                break;
            end
            step(1);
        end
        check("rstw_saw_write", 32'(saw_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_rf_we", 32'(rf_we), 32'd0);
        check("rstw_in_ready", 32'(in_ready), 32'd1);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_res_valid", 32'(res_valid), 32'd0);
        check("rstw_op_count", 32'(op_count), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check("rstw_idle_after", 32'(busy), 32'd0);
        check("rstw_no_write", 32'(got_wr.size()), 32'd0);

        // 256 completed operations wrap the counter back to zero.
        for (int i = 0; i < 256; i++) push(rand_inst(3'b010));
        drain_and_compare("wrap");
        check("wrap_op_count", 32'(op_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
